// File: rtl/fp32_pkg.sv
// Shared single-precision constants and the float_to_int FSM encoding.
`timescale 1ns/1ps
package fp32_pkg;

    localparam logic [7:0]  EXP_BIAS    = 8'd127;
    localparam logic [7:0]  EXP_SPECIAL = 8'd255;
    localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN   = 32'h8000_0000;

    // Exponent breakpoints: right-shift window covers u=-1..23, left-shift u=24..30.
    localparam logic [7:0]  EXP_RSH_LO  = EXP_BIAS - 8'd1;
    localparam logic [7:0]  EXP_RSH_HI  = EXP_BIAS + 8'd23;
    localparam logic [7:0]  EXP_LSH_HI  = EXP_BIAS + 8'd30;
    localparam logic [7:0]  EXP_SAT     = EXP_BIAS + 8'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ROUND = 2'd2,
        ST_PACK  = 2'd3
    } fti_state_t;

endpackage

// File: rtl/fti_align_shifter.sv
// Aligns the 24-bit significand to an integer part plus guard/sticky bits
// according to the unbiased exponent u = e - 127.
`timescale 1ns/1ps
module fti_align_shifter
    import fp32_pkg::*;
(
    input  logic [23:0] m,
    input  logic [7:0]  e,
    output logic [31:0] int_part,
    output logic        guard,
    output logic        sticky
);

    logic [55:0] wide;
    logic [7:0]  rsh;
    logic [7:0]  lsh;

    always_comb begin
        int_part = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        wide     = '0;
        rsh      = '0;
        lsh      = '0;
        if (e >= EXP_RSH_LO && e <= EXP_RSH_HI) begin
            // Fraction bits land in wide[23:0]; bit 23 is guard, the rest sticky.
            rsh      = EXP_RSH_HI - e;
            wide     = {8'b0, m, 24'b0} >> rsh;
            int_part = wide[55:24];
            guard    = wide[23];
            sticky   = |wide[22:0];
        end else if (e > EXP_RSH_HI && e <= EXP_LSH_HI) begin
            lsh      = e - EXP_RSH_HI;
            int_part = {8'b0, m} << lsh;
        end else if (e < EXP_RSH_LO) begin
            sticky   = |m;
        end
    end

endmodule

// File: rtl/float_to_int.sv
// Four-cycle IEEE 754 single-precision to int32 converter, round to nearest
// even, with saturation and invalid/inexact flags.
`timescale 1ns/1ps
module float_to_int
    import fp32_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact,
    output logic        done
);

    generate
        if (LATENCY != 4) begin : g_bad_latency
            $error("float_to_int supports only LATENCY=4");
        end
    endgenerate

    fti_state_t  state_reg;
    logic        sign_reg;
    logic [7:0]  exp_reg;
    logic [23:0] man_reg;
    logic [31:0] int_reg;
    logic        guard_reg;
    logic        sticky_reg;
    logic [31:0] mag_reg;
    logic        inexact_pend_reg;

    logic [31:0] shift_int;
    logic        shift_guard;
    logic        shift_sticky;
    logic        round_up;
    logic [31:0] pack_result;
    logic        pack_invalid;
    logic        pack_inexact;

    fti_align_shifter u_align (
        .m        (man_reg),
        .e        (exp_reg),
        .int_part (shift_int),
        .guard    (shift_guard),
        .sticky   (shift_sticky)
    );

    assign busy     = (state_reg != ST_IDLE);
    assign round_up = guard_reg & (sticky_reg | int_reg[0]);

    always_comb begin
        pack_result  = sign_reg ? (~mag_reg + 32'd1) : mag_reg;
        pack_invalid = 1'b0;
        pack_inexact = inexact_pend_reg;
        if (exp_reg == EXP_SPECIAL) begin
            pack_invalid = 1'b1;
            pack_inexact = 1'b0;
            pack_result  = (sign_reg && man_reg[22:0] == 23'd0) ? INT32_MIN : INT32_MAX;
        end else if (exp_reg >= EXP_SAT) begin
            // -2^31 is exactly representable, so it alone is not an overflow.
            pack_inexact = 1'b0;
            pack_result  = sign_reg ? INT32_MIN : INT32_MAX;
            pack_invalid = !(sign_reg && exp_reg == EXP_SAT && man_reg[22:0] == 23'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            sign_reg         <= 1'b0;
            exp_reg          <= '0;
            man_reg          <= '0;
            int_reg          <= '0;
            guard_reg        <= 1'b0;
            sticky_reg       <= 1'b0;
            mag_reg          <= '0;
            inexact_pend_reg <= 1'b0;
            result           <= '0;
            invalid          <= 1'b0;
            inexact          <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sign_reg  <= a[31];
                        exp_reg   <= a[30:23];
                        man_reg   <= {|a[30:23], a[22:0]};
                        state_reg <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    int_reg    <= shift_int;
                    guard_reg  <= shift_guard;
                    sticky_reg <= shift_sticky;
                    state_reg  <= ST_ROUND;
                end
                ST_ROUND: begin
                    mag_reg          <= int_reg + {31'd0, round_up};
                    inexact_pend_reg <= guard_reg | sticky_reg;
                    state_reg        <= ST_PACK;
                end
                ST_PACK: begin
                    result    <= pack_result;
                    invalid   <= pack_invalid;
                    inexact   <= pack_inexact;
                    done      <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Randomized and directed bench for float_to_int against a real-arithmetic
// reference model of float-to-int32 conversion.
`timescale 1ns/1ps
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic        busy;
    logic [31:0] result;
    logic        invalid;
    logic        inexact;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    float_to_int #(.LATENCY(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .busy    (busy),
        .result  (result),
        .invalid (invalid),
        .inexact (inexact),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact value of the float as a real, then round half to even.
    function automatic void ref_model(input logic [31:0] op, output logic [31:0] r,
                                      output logic inv, output logic inx);
        int     e;
        int     scale;
        real    v;
        real    fl;
        real    diff;
        longint q;
        e   = int'(op[30:23]);
        r   = 32'd0;
        inv = 1'b0;
        inx = 1'b0;
        if (e == 255) begin
            inv = 1'b1;
            r   = (op[22:0] == 23'd0 && op[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        v     = real'(op[22:0]) + ((e != 0) ? 8388608.0 : 0.0);
        scale = (e != 0) ? e - 150 : -149;
        for (int i = 0; i < scale; i++) v = v * 2.0;
        for (int i = 0; i < -scale; i++) v = v / 2.0;
        if (v >= 2147483648.0) begin
            if (op[31] && v == 2147483648.0) begin
                r = 32'h8000_0000;
            end else begin
                inv = 1'b1;
                r   = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            return;
        end
        fl   = $floor(v);
        diff = v - fl;
        q    = longint'(fl);
        if (diff > 0.5 || (diff == 0.5 && q[0])) q = q + 1;
        inx = (diff != 0.0);
        if (op[31]) q = -q;
        r = q[31:0];
    endfunction

    // Starts one conversion from IDLE and waits for done, checking latency.
    task automatic run_conv(input logic [31:0] op, output logic [31:0] r,
                            output logic inv, output logic inx);
        int n;
        @(negedge clk);
        a     = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency %h", op), 32'(n), 32'd3);
        r   = result;
        inv = invalid;
        inx = inexact;
        $display("[TB] conv a=%h result=%h invalid=%0b inexact=%0b", op, r, inv, inx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, er;
        logic        inv, inx, einv, einx;
        logic [31:0] op;
        int          d_cnt, first, second, n;

        vecs[0]  = '{32'h40490FDB, 32'h0000_0003, 1'b0, 1'b1};
        vecs[1]  = '{32'h40200000, 32'h0000_0002, 1'b0, 1'b1};
        vecs[2]  = '{32'h40600000, 32'h0000_0004, 1'b0, 1'b1};
        vecs[3]  = '{32'hBFC00000, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[4]  = '{32'h3F000000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[5]  = '{32'h4F000000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'hCF000000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[7]  = '{32'h7FC00000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[8]  = '{32'hFF800000, 32'h8000_0000, 1'b1, 1'b0};
        vecs[9]  = '{32'h4EFFFFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000001, 32'h0000_0000, 1'b0, 1'b1};
        vecs[12] = '{32'h42280000, 32'h0000_002A, 1'b0, 1'b0};
        vecs[13] = '{32'h7F800000, 32'h7FFF_FFFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, busy, invalid, inexact}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_conv(vecs[i].op, r, inv, inx);
            check($sformatf("dir result %h", vecs[i].op), r, vecs[i].res);
            check($sformatf("dir invalid %h", vecs[i].op), {31'd0, inv}, {31'd0, vecs[i].inv});
            check($sformatf("dir inexact %h", vecs[i].op), {31'd0, inx}, {31'd0, vecs[i].inx});
        end

        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            op[31]    = 1'($urandom_range(0, 1));
            op[30:23] = (sel == 0) ? (($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0)
                                   : 8'($urandom_range(100, 160));
            op[22:0]  = 23'($urandom);
            if (sel == 1) op[22:0] = op[22:0] & 23'h7FF000;
            ref_model(op, er, einv, einx);
            run_conv(op, r, inv, inx);
            check($sformatf("rnd result %h", op), r, er);
            check($sformatf("rnd flags %h", op), {30'd0, inv, inx}, {30'd0, einv, einx});
        end

        // start held high for 10 edges: captures every 4th edge.
        @(negedge clk);
        a      = 32'h41200000;
        start  = 1'b1;
        d_cnt  = 0;
        first  = -1;
        second = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                d_cnt++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        start = 1'b0;
        $display("[TB] b2b dones=%0d at edges %0d,%0d result=%h", d_cnt, first, second, result);
        check("b2b done count", 32'(d_cnt), 32'd2);
        check("b2b spacing", 32'(second - first), 32'd4);
        check("b2b result", result, 32'd10);
        n = 0;
        while ((busy || done) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b drain", {31'd0, busy}, 32'd0);

        // start pulsed while busy must not launch a second conversion.
        @(negedge clk);
        a     = 32'h40E00000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        a     = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) d_cnt++;
        end
        $display("[TB] busy-ignore dones=%0d result=%h", d_cnt, result);
        check("busy ignore count", 32'(d_cnt), 32'd1);
        check("busy ignore result", result, 32'd7);

        // Reset during ROUND aborts the conversion.
        @(negedge clk);
        a     = 32'h41200000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset result", result, 32'd0);
        check("mid reset busy/done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) d_cnt++;
        end
        $display("[TB] mid-reset dones after release=%0d", d_cnt);
        check("mid reset no done", 32'(d_cnt), 32'd0);
        run_conv(32'h42280000, r, inv, inx);
        check("post reset result", r, 32'd42);
        check("post reset flags", {30'd0, inv, inx}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
